load_store_unit: RTL and testbench
==================================

Name: load_store_unit

Overview:
- Sits directly upstream of the 4-bank byte-lane RAM. Turns byte-addressed CPU load/store requests (byte, half, word) into RAM bank-select, word-address and lane-steered write-data cycles.
- Extracts and sign- or zero-extends load data from the RAM's registered read port.
- Returns one response per request over a valid/ready request channel and a one-cycle response pulse.
- Checks alignment and reports misaligned or invalid requests without touching the RAM.

Parameters:
- ADDR_WIDTH, 12, byte-address width. Word address is ADDR_WIDTH-2 bits and matches the 10-bit RAM address.

Ports:
- clock  in  1  system clock; all logic is on its rising edge
- reset  in  1  synchronous reset, active-high
- req_valid  in  1  request present
- req_ready  out  1  unit can accept a request (idle)
- req_we  in  1  1 = store, 0 = load
- req_size  in  2  00 byte, 01 half, 10 word, 11 invalid
- req_signed  in  1  sign-extend load result (ignored for word and stores)
- req_addr  in  ADDR_WIDTH  byte address
- req_wdata  in  32  store data, right-justified
- resp_valid  out  1  one-cycle response pulse
- resp_rdata  out  32  extended load data; 0 for stores and errors
- resp_error  out  1  misaligned or invalid size; qualified by resp_valid
- ram_enable  out  1  to RAM enable
- ram_bank_select  out  4  to RAM bank_select; bit k = byte lane k = data bits [8k+7:8k]
- ram_addr  out  ADDR_WIDTH-2  req_addr[ADDR_WIDTH-1:2]
- ram_di  out  32  lane-replicated store data
- ram_we  out  1  to RAM we
- ram_do  in  32  RAM read data, valid the cycle after the RAM edge that sampled enable

Behaviour:
- Reset:
  - state=IDLE.
  - ram_enable, ram_we, ram_bank_select, ram_addr, ram_di, resp_valid, resp_rdata and resp_error are all 0.
  - req_ready=0 while reset is high.
- FSM states: IDLE, ACCESS, CAPTURE, RESP. req_ready = (state==IDLE) & ~reset.
- IDLE: on req_valid & req_ready, latch we, size, signed, addr and wdata.
  - Misaligned or invalid request (size 11; half with addr[0]=1; word with addr[1:0]!=0):
    - go to RESP with resp_error=1 and resp_rdata=0.
    - ram_enable stays 0.
  - Otherwise:
    - go to ACCESS and register the RAM outputs.
    - ram_enable=1, ram_we=req_we, ram_addr=word address.
    - Lane mask: byte = 1<<addr[1:0]; half = 0011 or 1100 by addr[1]; word = 1111.
    - ram_di: byte {4{wdata[7:0]}}, half {2{wdata[15:0]}}, word wdata.
- ACCESS: the RAM outputs are asserted for exactly this one cycle, and the RAM samples them at the closing edge.
  - Next state is CAPTURE.
  - At the transition, ram_enable, ram_we and ram_bank_select return to 0.
- CAPTURE: ram_do is valid.
  - Load: select the byte lane (addr[1:0]) or half lane (addr[1]), then zero- or sign-extend it, or pass the whole word. Register the result into resp_rdata.
  - Store: resp_rdata=0.
  - resp_error=0. Next state is RESP.
  - Lanes not selected in ram_do are stale and must never reach resp_rdata.
- RESP: resp_valid=1 for exactly one cycle; next state is IDLE. The response cannot be back-pressured.
- Latency, counting the accept edge as E0:
  - Valid request: resp_valid is high in the cycle after E3 −1, i.e. the third cycle after E0. Throughput is one request per 4 cycles.
  - Error: resp_valid is high in the first cycle after E0.
- resp_rdata and resp_error hold their values until the next response is written.
- Only one request is outstanding at a time. req_valid while busy is ignored and is not queued.
- Reset asserted in any state:
  - Go to IDLE next edge and drop all RAM controls the same edge.
  - No resp_valid is issued for the aborted request.
  - A store whose ACCESS edge has already occurred stays written in the RAM.

Decomposition:
- Shared package mem_pkg:
  - size encodings SIZE_BYTE=2'b00, SIZE_HALF=2'b01, SIZE_WORD=2'b10.
  - FSM state encoding.
  - lane-mask function.
- One natural sub-module, lsu_lane_align. It is combinational and holds two functions:
  - store side: size and addr[1:0] → bank mask plus replicated ram_di.
  - load side: ram_do, size, addr[1:0] and signed → extended 32-bit result.
- The FSM and registers live in load_store_unit.

Test Plan:
- Word store then load: store addr 0x010, wdata 0xDEADBEEF, then load word at 0x010.
  - Store: ram_addr=4, mask 1111, ram_we=1 for one cycle, resp_valid 3 cycles after accept.
  - Load: resp_rdata=0xDEADBEEF.
- Byte stores: store byte 0x80 at 0x013, then load byte at 0x013.
  - Store: mask 1000, ram_di=0x80808080.
  - Signed load → 0xFFFFFF80. Unsigned load → 0x00000080. The other lanes of word 4 are unchanged.
- Half stores: store half 0x8001 at 0x022, then load half at 0x022.
  - Store: mask 1100.
  - Signed load → 0xFFFF8001. Unsigned load → 0x00008001. Load word at 0x020 → lanes [31:16]=0x8001.
- Errors: half at 0x001, word at 0x006, size 11.
  - Each gives resp_error=1 and resp_rdata=0 one cycle after accept.
  - ram_enable never goes high, and the next valid request completes normally.
- Back-to-back requests: req_valid held high with 3 queued requests.
  - req_ready is high only in IDLE; accepts are 4 cycles apart; 3 resp_valid pulses come back in order.
- Reset in CAPTURE during a load: no resp_valid pulse.
  - After reset, req_ready=1 and all RAM controls are 0.
  - Loading the same address returns the correct data.

Source files
------------

// File: rtl/mem_pkg.sv
// Shared definitions for the load/store unit: access sizes, FSM states
// and the byte-lane helpers used on both the store and the load path.
package mem_pkg;

    localparam logic [1:0] SIZE_BYTE = 2'b00;
    localparam logic [1:0] SIZE_HALF = 2'b01;
    localparam logic [1:0] SIZE_WORD = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ACCESS  = 2'd1,
        ST_CAPTURE = 2'd2,
        ST_RESP    = 2'd3
    } lsu_state_e;

    function automatic logic [3:0] lane_mask(input logic [1:0] size, input logic [1:0] offset);
        case (size)
            SIZE_BYTE: lane_mask = 4'b0001 << offset;
            SIZE_HALF: lane_mask = offset[1] ? 4'b1100 : 4'b0011;
            SIZE_WORD: lane_mask = 4'b1111;
            default:   lane_mask = 4'b0000;
        endcase
    endfunction

    // Size 11 is never legal; halves need an even address, words a multiple of 4.
    function automatic logic is_bad_request(input logic [1:0] size, input logic [1:0] offset);
        case (size)
            SIZE_BYTE: is_bad_request = 1'b0;
            SIZE_HALF: is_bad_request = offset[0];
            SIZE_WORD: is_bad_request = (offset != 2'b00);
            default:   is_bad_request = 1'b1;
        endcase
    endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// Combinational byte-lane steering: replicates store data across lanes and
// extracts/extends the addressed lane(s) of a RAM read word.
module lsu_lane_align
    import mem_pkg::*;
(
    input  logic [1:0]  size,
    input  logic [1:0]  offset,
    input  logic        is_signed,
    input  logic [31:0] wdata,
    input  logic [31:0] rdata,
    output logic [3:0]  bank_mask,
    output logic [31:0] store_data,
    output logic [31:0] load_data
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        bank_mask = lane_mask(size, offset);
        case (size)
            SIZE_BYTE: store_data = {4{wdata[7:0]}};
            SIZE_HALF: store_data = {2{wdata[15:0]}};
            SIZE_WORD: store_data = wdata;
            default:   store_data = '0;
        endcase
    end

    // Only the addressed lane(s) may reach load_data; the rest of rdata is stale.
    always_comb begin
        case (offset)
            2'd1:    byte_sel = rdata[15:8];
            2'd2:    byte_sel = rdata[23:16];
            2'd3:    byte_sel = rdata[31:24];
            default: byte_sel = rdata[7:0];
        endcase
        half_sel = offset[1] ? rdata[31:16] : rdata[15:0];
        case (size)
            SIZE_BYTE: load_data = {{24{is_signed & byte_sel[7]}}, byte_sel};
            SIZE_HALF: load_data = {{16{is_signed & half_sel[15]}}, half_sel};
            SIZE_WORD: load_data = rdata;
            default:   load_data = '0;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit: turns byte-addressed CPU requests into single-cycle
// accesses of a 4-bank byte-lane RAM and returns one response per request.
module load_store_unit
    import mem_pkg::*;
#(
    parameter int ADDR_WIDTH = 12
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_we,
    input  logic [1:0]            req_size,
    input  logic                  req_signed,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [31:0]           req_wdata,
    output logic                  resp_valid,
    output logic [31:0]           resp_rdata,
    output logic                  resp_error,
    output logic                  ram_enable,
    output logic [3:0]            ram_bank_select,
    output logic [ADDR_WIDTH-3:0] ram_addr,
    output logic [31:0]           ram_di,
    output logic                  ram_we,
    input  logic [31:0]           ram_do
);

    lsu_state_e            state_q, state_d;
    logic                  we_q, we_d;
    logic [1:0]            size_q, size_d;
    logic                  signed_q, signed_d;
    logic [1:0]            offset_q, offset_d;
    logic                  ram_enable_q, ram_enable_d;
    logic                  ram_we_q, ram_we_d;
    logic [3:0]            ram_bank_select_q, ram_bank_select_d;
    logic [ADDR_WIDTH-3:0] ram_addr_q, ram_addr_d;
    logic [31:0]           ram_di_q, ram_di_d;
    logic                  resp_valid_q, resp_valid_d;
    logic [31:0]           resp_rdata_q, resp_rdata_d;
    logic                  resp_error_q, resp_error_d;

    logic [1:0]  align_size;
    logic [1:0]  align_offset;
    logic [3:0]  align_mask;
    logic [31:0] align_di;
    logic [31:0] align_load;

    // In IDLE the aligner sees the incoming request (store side); afterwards the latched one (load side).
    assign align_size   = (state_q == ST_IDLE) ? req_size : size_q;
    assign align_offset = (state_q == ST_IDLE) ? req_addr[1:0] : offset_q;

    lsu_lane_align u_lane_align (
        .size       (align_size),
        .offset     (align_offset),
        .is_signed  (signed_q),
        .wdata      (req_wdata),
        .rdata      (ram_do),
        .bank_mask  (align_mask),
        .store_data (align_di),
        .load_data  (align_load)
    );

    always_comb begin
        state_d           = state_q;
        we_d              = we_q;
        size_d            = size_q;
        signed_d          = signed_q;
        offset_d          = offset_q;
        ram_enable_d      = 1'b0;
        ram_we_d          = 1'b0;
        ram_bank_select_d = 4'b0000;
        ram_addr_d        = ram_addr_q;
        ram_di_d          = ram_di_q;
        resp_valid_d      = 1'b0;
        resp_rdata_d      = resp_rdata_q;
        resp_error_d      = resp_error_q;
        case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    we_d     = req_we;
                    size_d   = req_size;
                    signed_d = req_signed;
                    offset_d = req_addr[1:0];
                    if (is_bad_request(req_size, req_addr[1:0])) begin
                        state_d      = ST_RESP;
                        resp_valid_d = 1'b1;
                        resp_error_d = 1'b1;
                        resp_rdata_d = '0;
                    end else begin
                        state_d           = ST_ACCESS;
                        ram_enable_d      = 1'b1;
                        ram_we_d          = req_we;
                        ram_bank_select_d = align_mask;
                        ram_addr_d        = req_addr[ADDR_WIDTH-1:2];
                        ram_di_d          = align_di;
                    end
                end
            end
            ST_ACCESS: state_d = ST_CAPTURE;
            ST_CAPTURE: begin
                state_d      = ST_RESP;
                resp_valid_d = 1'b1;
                resp_error_d = 1'b0;
                resp_rdata_d = we_q ? 32'd0 : align_load;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q           <= ST_IDLE;
            we_q              <= 1'b0;
            size_q            <= 2'b00;
            signed_q          <= 1'b0;
            offset_q          <= 2'b00;
            ram_enable_q      <= 1'b0;
            ram_we_q          <= 1'b0;
            ram_bank_select_q <= 4'b0000;
            ram_addr_q        <= '0;
            ram_di_q          <= '0;
            resp_valid_q      <= 1'b0;
            resp_rdata_q      <= '0;
            resp_error_q      <= 1'b0;
        end else begin
            state_q           <= state_d;
            we_q              <= we_d;
            size_q            <= size_d;
            signed_q          <= signed_d;
            offset_q          <= offset_d;
            ram_enable_q      <= ram_enable_d;
            ram_we_q          <= ram_we_d;
            ram_bank_select_q <= ram_bank_select_d;
            ram_addr_q        <= ram_addr_d;
            ram_di_q          <= ram_di_d;
            resp_valid_q      <= resp_valid_d;
            resp_rdata_q      <= resp_rdata_d;
            resp_error_q      <= resp_error_d;
        end
    end

    assign req_ready       = (state_q == ST_IDLE) & ~reset;
    assign ram_enable      = ram_enable_q;
    assign ram_we          = ram_we_q;
    assign ram_bank_select = ram_bank_select_q;
    assign ram_addr        = ram_addr_q;
    assign ram_di          = ram_di_q;
    assign resp_valid      = resp_valid_q;
    assign resp_rdata      = resp_rdata_q;
    assign resp_error      = resp_error_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: a byte-lane RAM model drives ram_do,
// and a byte-array memory model supplies every expected response.
module tb_load_store_unit;

    logic        clock;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [1:0]  req_size;
    logic        req_signed;
    logic [11:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_error;
    logic        ram_enable;
    logic [3:0]  ram_bank_select;
    logic [9:0]  ram_addr;
    logic [31:0] ram_di;
    logic        ram_we;
    logic [31:0] ram_do = 32'hA5A5_A5A5;

    int errors = 0;
    int checks = 0;

    logic [7:0] ram_bank [4][1024];
    logic [7:0] ref_mem [4096];

    int          en_cnt = 0;
    int          we_cnt = 0;
    logic [3:0]  mon_mask;
    logic [9:0]  mon_addr;
    logic [31:0] mon_di;
    logic [31:0] last_rdata;

    load_store_unit #(.ADDR_WIDTH(12)) dut (
        .clock           (clock),
        .reset           (reset),
        .req_valid       (req_valid),
        .req_ready       (req_ready),
        .req_we          (req_we),
        .req_size        (req_size),
        .req_signed      (req_signed),
        .req_addr        (req_addr),
        .req_wdata       (req_wdata),
        .resp_valid      (resp_valid),
        .resp_rdata      (resp_rdata),
        .resp_error      (resp_error),
        .ram_enable      (ram_enable),
        .ram_bank_select (ram_bank_select),
        .ram_addr        (ram_addr),
        .ram_di          (ram_di),
        .ram_we          (ram_we),
        .ram_do          (ram_do)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Banked RAM with a registered read port; unselected read lanes keep stale data.
    always @(posedge clock) begin
        if (ram_enable) begin
            for (int k = 0; k < 4; k++) begin
                if (ram_bank_select[k]) begin
                    if (ram_we) ram_bank[k][ram_addr] <= ram_di[8*k +: 8];
                    else        ram_do[8*k +: 8] <= ram_bank[k][ram_addr];
                end
            end
        end
    end

    always @(negedge clock) begin
        if (ram_enable) begin
            en_cnt   <= en_cnt + 1;
            mon_mask <= ram_bank_select;
            mon_addr <= ram_addr;
            mon_di   <= ram_di;
        end
        if (ram_we) we_cnt <= we_cnt + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s: observed=%08h expected=%08h", tag, obs, exp);
        end
    endtask

    // Reference memory: byte-addressed array, little-endian lane order.
    function automatic logic [31:0] model_access(input logic we, input logic [1:0] size,
                                                 input logic sgn, input logic [11:0] addr,
                                                 input logic [31:0] wdata);
        int n = 1 << size;
        int a = int'(addr);
        logic [31:0] v = '0;
        for (int i = 0; i < n; i++) begin
            if (we) ref_mem[a + i] = 8'(wdata >> (8 * i));
            else    v = v | (32'(ref_mem[a + i]) << (8 * i));
        end
        if (!we && sgn && n < 4 && v[8*n-1]) v = v | (32'hFFFF_FFFF << (8 * n));
        return v;
    endfunction

    task automatic do_req(input string tag, input logic we, input logic [1:0] size,
                          input logic sgn, input logic [11:0] addr, input logic [31:0] wdata);
        int n;
        int off;
        int waited;
        int lat;
        int en0;
        int we0;
        logic err;
        logic [31:0] exp_rd;
        logic [31:0] exp_di;
        logic [31:0] lane_bits;
        logic [3:0]  exp_mask;
        n = (size == 2'b11) ? 1 : (1 << size);
        off = int'(addr[1:0]);
        err = (size == 2'b11) || ((int'(addr) % n) != 0);
        exp_rd = '0;
        exp_di = '0;
        lane_bits = '0;
        exp_mask = '0;
        if (!err) begin
            for (int i = 0; i < n; i++) begin
                exp_mask[off + i] = 1'b1;
                exp_di[8*(off+i) +: 8] = 8'(wdata >> (8 * i));
                lane_bits[8*(off+i) +: 8] = 8'hFF;
            end
            exp_rd = model_access(we, size, sgn, addr, wdata);
            if (we) exp_rd = '0;
        end
        waited = 0;
        @(negedge clock);
        while (!req_ready && waited < 20) begin
            @(negedge clock);
            waited++;
        end
        if (!req_ready) check({tag, "_ready_timeout"}, 32'(req_ready), 32'd1);
        req_valid = 1'b1;
        req_we = we;
        req_size = size;
        req_signed = sgn;
        req_addr = addr;
        req_wdata = wdata;
        en0 = en_cnt;
        we0 = we_cnt;
        @(posedge clock);
        #1 req_valid = 1'b0;
        lat = 0;
        do begin
            @(negedge clock);
            lat++;
        end while (!resp_valid && lat < 8);
        last_rdata = resp_rdata;
        check({tag, "_latency"}, 32'(lat), err ? 32'd1 : 32'd3);
        check({tag, "_error"}, 32'(resp_error), 32'(err));
        check({tag, "_rdata"}, resp_rdata, exp_rd);
        check({tag, "_en_cycles"}, 32'(en_cnt - en0), err ? 32'd0 : 32'd1);
        check({tag, "_we_cycles"}, 32'(we_cnt - we0), (!err && we) ? 32'd1 : 32'd0);
        if (!err) begin
            check({tag, "_mask"}, 32'(mon_mask), 32'(exp_mask));
            check({tag, "_addr"}, 32'(mon_addr), 32'(addr[11:2]));
            if (we) check({tag, "_di_lanes"}, mon_di & lane_bits, exp_di);
        end
    endtask

    initial begin
        int cyc;
        int acc;
        int got;
        int last_acc;
        logic        bb_we   [3];
        logic [1:0]  bb_size [3];
        logic        bb_sgn  [3];
        logic [11:0] bb_addr [3];
        logic [31:0] bb_wdata[3];
        logic [31:0] bb_exp  [3];

        for (int a = 0; a < 4096; a++) begin
            ref_mem[a] = 8'(a * 37 + 11);
            ram_bank[a % 4][a / 4] = 8'(a * 37 + 11);
        end
        reset = 1'b1;
        req_valid = 1'b0;
        req_we = 1'b0;
        req_size = 2'b00;
        req_signed = 1'b0;
        req_addr = '0;
        req_wdata = '0;
        last_rdata = '0;

        repeat (2) @(posedge clock);
        @(negedge clock);
        check("rst_ready", 32'(req_ready), 32'd0);
        check("rst_resp_valid", 32'(resp_valid), 32'd0);
        check("rst_ram_ctrl", {ram_enable, ram_we, ram_bank_select, 16'd0, ram_addr}, 32'd0);
        check("rst_ram_di", ram_di, 32'd0);
        check("rst_rdata", resp_rdata, 32'd0);
        check("rst_error", 32'(resp_error), 32'd0);
        reset = 1'b0;
        @(negedge clock);
        check("post_rst_ready", 32'(req_ready), 32'd1);

        do_req("st_word", 1'b1, 2'b10, 1'b0, 12'h010, 32'hDEAD_BEEF);
        check("st_word_mask_const", 32'(mon_mask), 32'hF);
        check("st_word_addr_const", 32'(mon_addr), 32'd4);
        do_req("ld_word", 1'b0, 2'b10, 1'b0, 12'h010, 32'h0);
        check("ld_word_const", last_rdata, 32'hDEAD_BEEF);

        do_req("st_byte", 1'b1, 2'b00, 1'b0, 12'h013, 32'h0000_0080);
        check("st_byte_mask_const", 32'(mon_mask), 32'h8);
        check("st_byte_di_const", mon_di, 32'h8080_8080);
        do_req("ld_byte_s", 1'b0, 2'b00, 1'b1, 12'h013, 32'h0);
        check("ld_byte_s_const", last_rdata, 32'hFFFF_FF80);
        do_req("ld_byte_u", 1'b0, 2'b00, 1'b0, 12'h013, 32'h0);
        check("ld_byte_u_const", last_rdata, 32'h0000_0080);
        do_req("ld_word_after_byte", 1'b0, 2'b10, 1'b0, 12'h010, 32'h0);
        check("ld_word_after_byte_const", last_rdata, 32'h80AD_BEEF);

        do_req("st_half", 1'b1, 2'b01, 1'b0, 12'h022, 32'h0000_8001);
        check("st_half_mask_const", 32'(mon_mask), 32'hC);
        do_req("ld_half_s", 1'b0, 2'b01, 1'b1, 12'h022, 32'h0);
        check("ld_half_s_const", last_rdata, 32'hFFFF_8001);
        do_req("ld_half_u", 1'b0, 2'b01, 1'b0, 12'h022, 32'h0);
        check("ld_half_u_const", last_rdata, 32'h0000_8001);
        do_req("ld_word_020", 1'b0, 2'b10, 1'b0, 12'h020, 32'h0);
        check("ld_word_020_upper", last_rdata >> 16, 32'h0000_8001);

        do_req("err_half", 1'b0, 2'b01, 1'b0, 12'h001, 32'h0);
        do_req("err_word", 1'b1, 2'b10, 1'b0, 12'h006, 32'h1234_5678);
        do_req("err_size", 1'b0, 2'b11, 1'b0, 12'h000, 32'h0);
        do_req("after_err", 1'b0, 2'b10, 1'b0, 12'h010, 32'h0);

        bb_we    = '{1'b1, 1'b0, 1'b0};
        bb_size  = '{2'b10, 2'b01, 2'b00};
        bb_sgn   = '{1'b0, 1'b0, 1'b1};
        bb_addr  = '{12'h030, 12'h032, 12'h031};
        bb_wdata = '{32'h1234_F678, 32'h0, 32'h0};
        for (int i = 0; i < 3; i++) begin
            bb_exp[i] = model_access(bb_we[i], bb_size[i], bb_sgn[i], bb_addr[i], bb_wdata[i]);
            if (bb_we[i]) bb_exp[i] = '0;
        end
        req_valid = 1'b1;
        acc = 0;
        got = 0;
        cyc = 0;
        last_acc = 0;
        while (got < 3 && cyc < 80) begin
            @(negedge clock);
            cyc++;
            if (resp_valid) begin
                check($sformatf("bb_rdata%0d", got), resp_rdata, bb_exp[got]);
                got++;
            end
            if (req_ready) begin
                if (acc < 3) begin
                    if (acc > 0) check("bb_accept_gap", 32'(cyc - last_acc), 32'd4);
                    last_acc = cyc;
                    req_we = bb_we[acc];
                    req_size = bb_size[acc];
                    req_signed = bb_sgn[acc];
                    req_addr = bb_addr[acc];
                    req_wdata = bb_wdata[acc];
                    acc++;
                end else begin
                    req_valid = 1'b0;
                end
            end
        end
        req_valid = 1'b0;
        check("bb_resp_count", 32'(got), 32'd3);

        // Abort a load in CAPTURE: no response may escape.
        @(negedge clock);
        while (!req_ready && cyc < 120) begin
            @(negedge clock);
            cyc++;
        end
        req_valid = 1'b1;
        req_we = 1'b0;
        req_size = 2'b10;
        req_signed = 1'b0;
        req_addr = 12'h010;
        @(posedge clock);
        #1 req_valid = 1'b0;
        @(negedge clock);
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        check("abort_resp_valid", 32'(resp_valid), 32'd0);
        check("abort_ram_ctrl", {ram_enable, ram_we, ram_bank_select, 16'd0, ram_addr}, 32'd0);
        check("abort_ram_di", ram_di, 32'd0);
        reset = 1'b0;
        #1 check("abort_ready", 32'(req_ready), 32'd1);
        @(negedge clock);
        check("abort_no_late_resp", 32'(resp_valid), 32'd0);
        do_req("after_abort", 1'b0, 2'b10, 1'b0, 12'h010, 32'h0);

        for (int i = 0; i < 40; i++) begin
            do_req($sformatf("rnd%0d", i), 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
                   1'($urandom_range(0, 1)), 12'($urandom_range(0, 63)), $urandom);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
